// File: rtl/varredura_display.sv
// Multiplexed 4-digit display scanner: mode letter plus three BCD digits, with blink and frame pulse.
// Ports: clock/reset_n (sync, active-low), enable, modo/valor/piscar in; digito/bcd/sel_modo/en_modo/frame out.
// Outputs decode registered state and enable only; inputs are sampled into shadows at frame boundaries.
module varredura_display #(
    parameter int DIV       = 4,   // cycles each digit stays selected (>= 2)
    parameter int BLINK_DIV = 8    // complete frames per blink-phase toggle (>= 1)
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  modo,
    input  logic [11:0] valor,
    input  logic        piscar,
    output logic [3:0]  digito,
    output logic [3:0]  bcd,
    output logic [1:0]  sel_modo,
    output logic        en_modo,
    output logic        frame
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [FW-1:0] FC_MAX  = FW'(BLINK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    idx_q, idx_d;
    logic [FW-1:0] fc_q, fc_d;
    logic          ph_q, ph_d;
    logic [1:0]    s_modo_q, s_modo_d;
    logic [11:0]   s_valor_q, s_valor_d;
    logic          s_piscar_q, s_piscar_d;

    logic          pre_last;
    logic          frame_end;

    assign pre_last  = (pre_q == PRE_MAX);
    assign frame_end = enable && pre_last && (idx_q == 2'd3);

    // Next-state logic
    always_comb begin
        pre_d      = pre_q;
        idx_d      = idx_q;
        fc_d       = fc_q;
        ph_d       = ph_q;
        s_modo_d   = s_modo_q;
        s_valor_d  = s_valor_q;
        s_piscar_d = s_piscar_q;

        if (!enable) begin
            // Blanked: restart scan from the mode digit; blink phase is kept
            pre_d = '0;
            idx_d = 2'd0;
            fc_d  = '0;
        end else begin
            pre_d = pre_last ? '0 : pre_q + PW'(1);
            if (pre_last) begin
                idx_d = idx_q + 2'd1;   // 2-bit index wraps 3 -> 0
            end
            if (frame_end) begin
                if (fc_q == FC_MAX) begin
                    fc_d = '0;
                    ph_d = ~ph_q;
                end else begin
                    fc_d = fc_q + FW'(1);
                end
            end
        end

        // Shadows only move between frames so a frame never mixes old and new values
        if (!enable || frame_end) begin
            s_modo_d   = modo;
            s_valor_d  = valor;
            s_piscar_d = piscar;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pre_q      <= '0;
            idx_q      <= 2'd0;
            fc_q       <= '0;
            ph_q       <= 1'b0;
            s_modo_q   <= 2'b00;
            s_valor_q  <= 12'h000;
            s_piscar_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            fc_q       <= fc_d;
            ph_q       <= ph_d;
            s_modo_q   <= s_modo_d;
            s_valor_q  <= s_valor_d;
            s_piscar_q <= s_piscar_d;
        end
    end

    // Output decode
    always_comb begin
        digito   = 4'b1111;
        bcd      = 4'b0000;
        sel_modo = 2'b00;
        en_modo  = 1'b0;
        frame    = 1'b0;

        if (reset_n && enable) begin
            frame = frame_end;
            case (idx_q)
                2'd0: begin
                    // Mode letter is never blinked
                    digito   = 4'b1110;
                    en_modo  = 1'b1;
                    sel_modo = s_modo_q;
                end
                2'd1: begin
                    digito = 4'b1101;
                    bcd    = s_valor_q[11:8];
                end
                2'd2: begin
                    digito = 4'b1011;
                    bcd    = s_valor_q[7:4];
                end
                default: begin
                    digito = 4'b0111;
                    bcd    = s_valor_q[3:0];
                end
            endcase
            // Blink blanks the digit strobe only; bcd keeps the nibble
            if (idx_q != 2'd0 && s_piscar_q && ph_q) begin
                digito = 4'b1111;
            end
        end
    end

endmodule

// File: tb/tb_varredura_display.sv
module tb_varredura_display;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic [1:0]  modo;
    logic [11:0] valor;
    logic        piscar;
    logic [3:0]  digito;
    logic [3:0]  bcd;
    logic [1:0]  sel_modo;
    logic        en_modo;
    logic        frame;

    int errors = 0;
    int checks = 0;

    varredura_display #(.DIV(4), .BLINK_DIV(2)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .enable   (enable),
        .modo     (modo),
        .valor    (valor),
        .piscar   (piscar),
        .digito   (digito),
        .bcd      (bcd),
        .sel_modo (sel_modo),
        .en_modo  (en_modo),
        .frame    (frame)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [1:0]  m;
        logic [11:0] v;
        logic        p;
        logic [3:0]  dig;
        logic [3:0]  nib;
        logic [1:0]  sel;
        logic        enm;
        logic        frm;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic [1:0] m, input logic [11:0] v,
                       input logic p, input logic [3:0] dig, input logic [3:0] nib,
                       input logic [1:0] sel, input logic enm, input logic frm);
        vec_t t;
        t.rst_n = r; t.en = e; t.m = m; t.v = v; t.p = p;
        t.dig = dig; t.nib = nib; t.sel = sel; t.enm = enm; t.frm = frm;
        vecs.push_back(t);
    endtask

    // n enabled cycles in one digit slot; frame expected on the final cycle when last=1
    task automatic add_slot(input logic [1:0] m, input logic [11:0] v, input logic p,
                            input int slot, input int n, input logic [1:0] esel,
                            input logic [3:0] nib, input logic blank, input logic last);
        logic [3:0] one;
        logic [3:0] dig;
        one = 4'b0001;
        for (int c = 0; c < n; c++) begin
            if (slot == 0) begin
                add(1'b1, 1'b1, m, v, p, 4'b1110, 4'h0, esel, 1'b1, 1'b0);
            end else begin
                dig = blank ? 4'b1111 : ~(one << slot);
                add(1'b1, 1'b1, m, v, p, dig, nib, 2'b00, 1'b0, last && (c == n - 1));
            end
        end
    endtask

    task automatic add_frame(input logic [1:0] m, input logic [11:0] v, input logic p,
                             input logic [1:0] esel, input logic [3:0] h, input logic [3:0] t,
                             input logic [3:0] u, input logic blank);
        add_slot(m, v, p, 0, 4, esel, 4'h0, 1'b0, 1'b0);
        add_slot(m, v, p, 1, 4, esel, h, blank, 1'b0);
        add_slot(m, v, p, 2, 4, esel, t, blank, 1'b0);
        add_slot(m, v, p, 3, 4, esel, u, blank, 1'b1);
    endtask

    initial begin
        int found;
        int gap;

        reset_n = 1'b0; enable = 1'b0; modo = 2'b00; valor = 12'h000; piscar = 1'b0;

        // Reset with enable high: blank; first released cycle shows mode digit with reset shadow
        add(1'b0, 1'b1, 2'b10, 12'h495, 1'b0, 4'b1111, 4'h0, 2'b00, 1'b0, 1'b0);
        add(1'b0, 1'b1, 2'b10, 12'h495, 1'b0, 4'b1111, 4'h0, 2'b00, 1'b0, 1'b0);
        add(1'b1, 1'b1, 2'b10, 12'h495, 1'b0, 4'b1110, 4'h0, 2'b00, 1'b1, 1'b0);

        // Load P / 495 while disabled, then two full frames
        add(1'b1, 1'b0, 2'b10, 12'h495, 1'b0, 4'b1111, 4'h0, 2'b00, 1'b0, 1'b0);
        add_frame(2'b10, 12'h495, 1'b0, 2'b10, 4'h4, 4'h9, 4'h5, 1'b0);
        add_frame(2'b10, 12'h495, 1'b0, 2'b10, 4'h4, 4'h9, 4'h5, 1'b0);

        // Tearing: valor changes at the 6th cycle of a frame
        add_slot(2'b10, 12'h495, 1'b0, 0, 4, 2'b10, 4'h0, 1'b0, 1'b0);
        add_slot(2'b10, 12'h495, 1'b0, 1, 1, 2'b10, 4'h4, 1'b0, 1'b0);
        add_slot(2'b10, 12'h123, 1'b0, 1, 3, 2'b10, 4'h4, 1'b0, 1'b0);
        add_slot(2'b10, 12'h123, 1'b0, 2, 4, 2'b10, 4'h9, 1'b0, 1'b0);
        add_slot(2'b10, 12'h123, 1'b0, 3, 4, 2'b10, 4'h5, 1'b0, 1'b1);
        add_frame(2'b10, 12'h123, 1'b0, 2'b10, 4'h1, 4'h2, 4'h3, 1'b0);

        // Blink: load A / 123 / piscar; frames 2 and 3 blank the value digits
        add(1'b1, 1'b0, 2'b11, 12'h123, 1'b1, 4'b1111, 4'h0, 2'b00, 1'b0, 1'b0);
        for (int f = 0; f < 5; f++) begin
            add_frame(2'b11, 12'h123, 1'b1, 2'b11, 4'h1, 4'h2, 4'h3, (f == 2) || (f == 3));
        end

        // Enable drop at idx 2, then re-enable with P / 495, no blink
        add_slot(2'b11, 12'h123, 1'b1, 0, 4, 2'b11, 4'h0, 1'b0, 1'b0);
        add_slot(2'b11, 12'h123, 1'b1, 1, 4, 2'b11, 4'h1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 2'b10, 12'h495, 1'b0, 4'b1111, 4'h0, 2'b00, 1'b0, 1'b0);
        add_slot(2'b10, 12'h495, 1'b0, 0, 4, 2'b10, 4'h0, 1'b0, 1'b0);
        add_slot(2'b10, 12'h495, 1'b0, 1, 4, 2'b10, 4'h4, 1'b0, 1'b0);
        add_slot(2'b10, 12'h495, 1'b0, 2, 4, 2'b10, 4'h9, 1'b0, 1'b0);
        add_slot(2'b10, 12'h495, 1'b0, 3, 3, 2'b10, 4'h5, 1'b0, 1'b0);

        // Reset in the last cycle of the frame: blank, no frame pulse, restart with zeroed shadows
        add(1'b0, 1'b1, 2'b10, 12'h495, 1'b0, 4'b1111, 4'h0, 2'b00, 1'b0, 1'b0);
        add_slot(2'b10, 12'h495, 1'b0, 0, 4, 2'b00, 4'h0, 1'b0, 1'b0);
        add_slot(2'b10, 12'h495, 1'b0, 1, 1, 2'b00, 4'h0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            @(negedge clock);
            reset_n = vecs[i].rst_n;
            enable  = vecs[i].en;
            modo    = vecs[i].m;
            valor   = vecs[i].v;
            piscar  = vecs[i].p;
            #2;
            checks++;
            if ({digito, bcd, sel_modo, en_modo, frame} !==
                {vecs[i].dig, vecs[i].nib, vecs[i].sel, vecs[i].enm, vecs[i].frm}) begin
                errors++;
                $display("FAIL vec%0d got dig=%b bcd=%h sel=%b en_modo=%b frame=%b, want dig=%b bcd=%h sel=%b en_modo=%b frame=%b",
                         i, digito, bcd, sel_modo, en_modo, frame,
                         vecs[i].dig, vecs[i].nib, vecs[i].sel, vecs[i].enm, vecs[i].frm);
            end
        end

        // Frame pulse period: the next pulse arrives within one frame, the one after exactly 16 cycles later
        found = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock); #2;
            if (frame) begin found = 1; break; end
        end
        checks++;
        if (found != 1) begin
            errors++;
            $display("FAIL frame_wait got no pulse in 20 cycles, want a pulse");
        end
        gap = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock); #2;
            if (frame) begin gap = c; break; end
        end
        checks++;
        if (gap != 16) begin
            errors++;
            $display("FAIL frame_gap got %0d cycles, want 16", gap);
        end

        // Held disable: several cycles stay blank with no pulse
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            enable = 1'b0;
            #2;
            checks++;
            if ({digito, en_modo, frame} !== {4'b1111, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL hold_disable got dig=%b en_modo=%b frame=%b, want dig=1111 en_modo=0 frame=0",
                         digito, en_modo, frame);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
